prog_sequencer: RTL and testbench

Test-and-run sequencer that sits directly upstream of the 3BC processor top level and drives its `Reset` and `Start` inputs. On a `Go` request it runs a fixed number of programs back to back: it resets the processor, pulses `Start`, counts cycles until `Ack`, and records the count per program. Recorded counts are readable through a combinational readout port. An optional watchdog abandons a program that never acknowledges.

---
 rtl/prog_sequencer.sv | 116 +++++++++++
 tb/tb_prog_sequencer.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/prog_sequencer.sv
// prog_sequencer: runs NUM_PROGS programs on a processor (reset, start, count cycles to Ack) and records per-program cycle counts; optional watchdog enabled by macro SEQ_TIMEOUT_EN
module prog_sequencer #(
  parameter int NUM_PROGS  = 3,
  parameter int RST_CYCLES = 2,
  parameter int CT_W       = 16,
  parameter int IDX_W      = (NUM_PROGS > 1) ? $clog2(NUM_PROGS) : 1
`ifdef SEQ_TIMEOUT_EN
  , parameter int TIMEOUT  = 16'hFFFF
`endif
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Go,
  input  logic             DutAck,
  output logic             DutReset,
  output logic             DutStart,
  output logic [IDX_W-1:0] ProgIdx,
  output logic             Busy,
  output logic             Done,
  input  logic [IDX_W-1:0] RdIdx,
  output logic [CT_W-1:0]  RdCycles,
  output logic             RdTimedOut
);
  localparam int RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_PROGS - 1);
  typedef enum logic [2:0] {S_IDLE, S_RST, S_START, S_RUN, S_DONE} state_t;
  state_t          r_state;
  logic [RW-1:0]   r_rst_ct;
  logic [CT_W-1:0] r_ct;
  logic [CT_W-1:0] r_slot [NUM_PROGS];
  logic            w_expire;
  logic            w_end;
  logic            w_rd_ok;
`ifdef SEQ_TIMEOUT_EN
  logic            r_tmo [NUM_PROGS];
  // On expiry the counter equals TIMEOUT, so recording r_ct stores TIMEOUT
  assign w_expire = !DutAck && (r_ct == CT_W'(TIMEOUT));
`else
  assign w_expire = 1'b0;
`endif
  assign w_end   = DutAck || w_expire;
  assign w_rd_ok = int'(RdIdx) < NUM_PROGS;
  assign RdCycles = w_rd_ok ? r_slot[RdIdx] : '0;
`ifdef SEQ_TIMEOUT_EN
  assign RdTimedOut = w_rd_ok ? r_tmo[RdIdx] : 1'b0;
`else
  assign RdTimedOut = 1'b0;
`endif
  // Sequencer FSM: all control outputs and result slots are registered here
  always_ff @(posedge Clk or negedge Reset)
    if (!Reset) begin
      r_state  <= S_IDLE;
      r_rst_ct <= '0;
      r_ct     <= '0;
      DutReset <= 1'b1;
      DutStart <= 1'b0;
      ProgIdx  <= '0;
      Busy     <= 1'b0;
      Done     <= 1'b0;
      for (int i = 0; i < NUM_PROGS; i++) begin
        r_slot[i] <= '0;
`ifdef SEQ_TIMEOUT_EN
        r_tmo[i]  <= 1'b0;
`endif
      end
    end else begin
      case (r_state)
        S_IDLE, S_DONE:
          if (Go) begin
            r_state  <= S_RST;
            r_rst_ct <= '0;
            DutReset <= 1'b1;
            ProgIdx  <= '0;
            Busy     <= 1'b1;
            Done     <= 1'b0;
            for (int i = 0; i < NUM_PROGS; i++) begin
              r_slot[i] <= '0;
`ifdef SEQ_TIMEOUT_EN
              r_tmo[i]  <= 1'b0;
`endif
            end
          end
        S_RST:
          if (r_rst_ct == RW'(RST_CYCLES - 1)) begin
            r_state  <= S_START;
            DutReset <= 1'b0;
            DutStart <= 1'b1;
          end else
            r_rst_ct <= r_rst_ct + 1'b1;
        S_START: begin
          r_state  <= S_RUN;
          DutStart <= 1'b0;
          r_ct     <= '0;
        end
        S_RUN:
          if (w_end) begin
            r_slot[ProgIdx] <= r_ct;
`ifdef SEQ_TIMEOUT_EN
            r_tmo[ProgIdx]  <= !DutAck;
`endif
            if (ProgIdx == LAST) begin
              r_state <= S_DONE;
              Busy    <= 1'b0;
              Done    <= 1'b1;
            end else begin
              r_state  <= S_RST;
              r_rst_ct <= '0;
              DutReset <= 1'b1;
              ProgIdx  <= ProgIdx + 1'b1;
            end
          end else if (r_ct != '1)
            r_ct <= r_ct + 1'b1;
        default: r_state <= S_IDLE;
      endcase
    end
endmodule

// File: tb/tb_prog_sequencer.sv
// tb_prog_sequencer: self-checking bench for prog_sequencer against a cycle-schedule reference model
module tb_prog_sequencer;
  localparam int NP = 3;
  localparam int RSTC = 2;
`ifdef SEQ_TIMEOUT_EN
  localparam int TMO = 20;
`else
  localparam int TMO = 1 << 30;
`endif
  logic Clk = 0, Reset, Go, DutAck;
  logic DutReset, DutStart, Busy, Done, RdTimedOut;
  logic [1:0] ProgIdx, RdIdx;
  logic [15:0] RdCycles;
  int n_tests = 0, n_fail = 0;
  typedef struct {bit rst; bit start; bit ack; int p;} cyc_t;
  cyc_t sched[$];
  int exp_cyc[NP];
  bit exp_to[NP];
  int d[NP];

  prog_sequencer #(.NUM_PROGS(NP), .RST_CYCLES(RSTC), .CT_W(16)
`ifdef SEQ_TIMEOUT_EN
    , .TIMEOUT(TMO)
`endif
  ) dut (
    .Clk(Clk), .Reset(Reset), .Go(Go), .DutAck(DutAck), .DutReset(DutReset),
    .DutStart(DutStart), .ProgIdx(ProgIdx), .Busy(Busy), .Done(Done),
    .RdIdx(RdIdx), .RdCycles(RdCycles), .RdTimedOut(RdTimedOut)
  );

  always #5 Clk = ~Clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected per-cycle behaviour from entering RST until DONE, plus the recorded results
  function automatic void build(input int dl[NP], input bit stale);
    sched.delete();
    for (int p = 0; p < NP; p++) begin
      int l;
      l = stale ? 0 : (dl[p] > TMO ? TMO : dl[p]);
      repeat (RSTC) sched.push_back('{1'b1, 1'b0, stale, p});
      sched.push_back('{1'b0, 1'b1, stale, p});
      for (int k = 0; k <= l; k++) sched.push_back('{1'b0, 1'b0, stale || k >= dl[p], p});
      exp_cyc[p] = l;
      exp_to[p] = !stale && dl[p] > TMO;
    end
  endfunction

  task automatic check_slots(input string tag);
    for (int i = 0; i < NP; i++) begin
      RdIdx = 2'(i);
      #1;
      chk($sformatf("%s:slot%0d", tag, i), 32'(RdCycles), exp_cyc[i]);
      chk($sformatf("%s:flag%0d", tag, i), 32'(RdTimedOut), 32'(exp_to[i]));
    end
  endtask

  task automatic run(input string tag, input int abort_at);
    Go = 1;
    tick();
    Go = 0;
    for (int i = 0; i < NP; i++) begin
      RdIdx = 2'(i);
      #1;
      chk($sformatf("%s:clr%0d", tag, i), 32'(RdCycles), 0);
      chk($sformatf("%s:clrflag%0d", tag, i), 32'(RdTimedOut), 0);
    end
    foreach (sched[i]) begin
      DutAck = sched[i].ack;
      Go = ($urandom_range(0, 3) == 0);
      if (i == abort_at) begin
        Reset = 0;
        #1;
        chk({tag, ":ab_dutreset"}, 32'(DutReset), 1);
        chk({tag, ":ab_dutstart"}, 32'(DutStart), 0);
        chk({tag, ":ab_busy"}, 32'(Busy), 0);
        chk({tag, ":ab_progidx"}, 32'(ProgIdx), 0);
        RdIdx = 0;
        #1;
        chk({tag, ":ab_slot0"}, 32'(RdCycles), 0);
        Go = 0;
        DutAck = 0;
        Reset = 1;
        tick();
        chk({tag, ":ab_idle_done"}, 32'(Done), 0);
        return;
      end
      chk($sformatf("%s:c%0d_dutreset", tag, i), 32'(DutReset), 32'(sched[i].rst));
      chk($sformatf("%s:c%0d_dutstart", tag, i), 32'(DutStart), 32'(sched[i].start));
      chk($sformatf("%s:c%0d_busy", tag, i), 32'(Busy), 1);
      chk($sformatf("%s:c%0d_done", tag, i), 32'(Done), 0);
      chk($sformatf("%s:c%0d_progidx", tag, i), 32'(ProgIdx), sched[i].p);
      tick();
    end
    Go = 0;
    DutAck = 0;
    chk({tag, ":done"}, 32'(Done), 1);
    chk({tag, ":busy_end"}, 32'(Busy), 0);
    chk({tag, ":dutreset_end"}, 32'(DutReset), 0);
    chk({tag, ":dutstart_end"}, 32'(DutStart), 0);
    chk({tag, ":progidx_end"}, 32'(ProgIdx), NP - 1);
    check_slots(tag);
  endtask

  initial begin
    int ab;
    Reset = 0; Go = 0; DutAck = 0; RdIdx = 0;
    repeat (2) @(posedge Clk);
    #1;
    chk("rst:dutreset", 32'(DutReset), 1);
    chk("rst:dutstart", 32'(DutStart), 0);
    chk("rst:progidx", 32'(ProgIdx), 0);
    chk("rst:busy", 32'(Busy), 0);
    chk("rst:done", 32'(Done), 0);
    exp_cyc = '{0, 0, 0};
    exp_to = '{0, 0, 0};
    check_slots("rst");
    Reset = 1;
    tick();
    chk("idle:dutreset", 32'(DutReset), 1);
    chk("idle:busy", 32'(Busy), 0);
    d = '{10, 10, 10};
    build(d, 0);
    run("basic", -1);
    RdIdx = 3;
    #1;
    chk("bounds:cycles", 32'(RdCycles), 0);
    chk("bounds:flag", 32'(RdTimedOut), 0);
    d = '{5, 5, 5};
    build(d, 1);
    run("stale", -1);
    for (int r = 0; r < 4; r++) begin
      for (int p = 0; p < NP; p++) d[p] = $urandom_range(0, 40);
      build(d, 0);
      run($sformatf("rand%0d", r), -1);
    end
`ifdef SEQ_TIMEOUT_EN
    d = '{25, 3, 60};
    build(d, 0);
    run("tmo", -1);
`else
    Go = 1;
    tick();
    Go = 0;
    DutAck = 0;
    for (int i = 0; i < 100; i++) begin
      chk($sformatf("noack:c%0d_busy", i), 32'(Busy), 1);
      chk($sformatf("noack:c%0d_progidx", i), 32'(ProgIdx), 0);
      tick();
    end
    Reset = 0;
    #1;
    Reset = 1;
    tick();
`endif
    d = '{8, 30, 8};
    build(d, 0);
    ab = -1;
    foreach (sched[i]) if (ab < 0 && sched[i].p == 1 && !sched[i].rst && !sched[i].start) ab = i + 3;
    run("abort", ab);
    d = '{7, 0, 12};
    build(d, 0);
    run("post", -1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
